// File: rtl/game_pkg.sv
// Shared state codes and display constants for the whack-a-mole game controller.
package game_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned TIME_W  = 7;
  localparam int unsigned BCD_W   = 8;
  localparam int unsigned BCD_MAX = 99;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAYING   = 3'd2,
    S_PAUSED    = 3'd3,
    S_GAME_OVER = 3'd4
  } state_e;

endpackage

// File: rtl/bin2bcd99.sv
// Combinational binary to two-digit BCD, saturating at 99.
module bin2bcd99
  import game_pkg::*;
#(
  parameter int unsigned IN_W = 8
) (
  input  logic [IN_W-1:0]  bin,
  output logic [BCD_W-1:0] bcd
);

  logic [6:0] sat;

  always_comb begin
    sat = (32'(bin) > BCD_MAX) ? 7'(BCD_MAX) : 7'(bin);
    bcd = {4'(sat / 7'd10), 4'(sat % 7'd10)};
  end

endmodule

// File: rtl/game_sequencer.sv
// Whack-a-mole game controller: IDLE -> COUNTDOWN -> PLAYING -> GAME_OVER with
// internal seconds timer and hi-score. Define GAME_PAUSE_EN to enable the PAUSED state.
module game_sequencer
  import game_pkg::*;
#(
  parameter  int unsigned TICK_CYCLES   = 100_000_000,
  parameter  int unsigned COUNTDOWN_SEC = 5,
  parameter  int unsigned GAME_SEC      = 30,
  parameter  int unsigned SCORE_W       = 8,
  parameter  int unsigned N_LEVELS      = 3,
  localparam int unsigned LVL_W         = $clog2(N_LEVELS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_start,
  input  logic               btn_pause,
  input  logic               btn_clear_score,
  input  logic               btn_difficulty,
  input  logic [SCORE_W-1:0] score,
  output logic [STATE_W-1:0] state_o,
  output logic               enable_score,
  output logic               enable_mole_ctrl,
  output logic               clear_score,
  output logic [LVL_W-1:0]   difficulty_level,
  output logic [TIME_W-1:0]  time_left,
  output logic [BCD_W-1:0]   display_left,
  output logic [BCD_W-1:0]   display_right,
  output logic [SCORE_W-1:0] hi_score,
  output logic               game_over_pulse,
  output logic               new_hi_pulse
);

  localparam int unsigned PRESC_W = $clog2(TICK_CYCLES);
  localparam int unsigned LEFT_W  = (SCORE_W > TIME_W) ? SCORE_W : TIME_W;

  state_e               state_q, state_d;
  logic [TIME_W-1:0]    tl_q, tl_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [LVL_W-1:0]     lvl_q, lvl_d, lvl_inc;
  logic [SCORE_W-1:0]   hi_q, hi_d;
  logic                 clr_q, clr_d;
  logic                 go_q, go_d;
  logic                 nh_q, nh_d;
  logic                 en_q, en_d;
  logic                 tick;

`ifndef GAME_PAUSE_EN
  logic unused_pause;
  assign unused_pause = btn_pause;
`endif

  assign tick    = ((state_q == S_COUNTDOWN) || (state_q == S_PLAYING)) &&
                   (presc_q == PRESC_W'(TICK_CYCLES - 1));
  assign lvl_inc = (lvl_q == LVL_W'(N_LEVELS - 1)) ? '0 : lvl_q + LVL_W'(1);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tl_q    <= '0;
      presc_q <= '0;
      lvl_q   <= '0;
      hi_q    <= '0;
      clr_q   <= 1'b0;
      go_q    <= 1'b0;
      nh_q    <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tl_q    <= tl_d;
      presc_q <= presc_d;
      lvl_q   <= lvl_d;
      hi_q    <= hi_d;
      clr_q   <= clr_d;
      go_q    <= go_d;
      nh_q    <= nh_d;
      en_q    <= en_d;
    end
  end

  // Next-state logic; priority is start > tick > pause > clear
  always_comb begin
    state_d = state_q;
    tl_d    = tl_q;
    presc_d = presc_q;
    lvl_d   = lvl_q;
    hi_d    = hi_q;
    clr_d   = 1'b0;
    go_d    = 1'b0;
    nh_d    = 1'b0;

    case (state_q)
      S_IDLE, S_GAME_OVER: begin
        presc_d = '0;
        if (btn_difficulty) lvl_d = lvl_inc;
        if (btn_start) begin
          state_d = S_COUNTDOWN;
          tl_d    = TIME_W'(COUNTDOWN_SEC);
          clr_d   = 1'b1;
        end else if (btn_clear_score) begin
          clr_d = 1'b1;
          hi_d  = '0;
        end
      end

      S_COUNTDOWN: begin
        presc_d = tick ? '0 : presc_q + PRESC_W'(1);
        if (btn_start) begin
          tl_d    = TIME_W'(COUNTDOWN_SEC);
          presc_d = '0;
        end else if (tick) begin
          if (tl_q == TIME_W'(1)) begin
            state_d = S_PLAYING;
            tl_d    = TIME_W'(GAME_SEC);
          end else begin
            tl_d = tl_q - TIME_W'(1);
          end
        end
      end

      S_PLAYING: begin
        presc_d = tick ? '0 : presc_q + PRESC_W'(1);
        if (btn_start) begin
          state_d = S_COUNTDOWN;
          tl_d    = TIME_W'(COUNTDOWN_SEC);
          presc_d = '0;
          clr_d   = 1'b1;
        end else if (tick) begin
          if (tl_q == TIME_W'(1)) begin
            state_d = S_GAME_OVER;
            tl_d    = '0;
            go_d    = 1'b1;
            if (score > hi_q) begin
              hi_d = score;
              nh_d = 1'b1;
            end
          end else begin
            tl_d = tl_q - TIME_W'(1);
          end
        end
`ifdef GAME_PAUSE_EN
        else if (btn_pause) begin
          state_d = S_PAUSED;
          presc_d = presc_q;
        end
`endif
        else if (btn_clear_score) begin
          clr_d = 1'b1;
        end
      end

`ifdef GAME_PAUSE_EN
      S_PAUSED: begin
        if (btn_start) begin
          state_d = S_COUNTDOWN;
          tl_d    = TIME_W'(COUNTDOWN_SEC);
          presc_d = '0;
          clr_d   = 1'b1;
        end else if (btn_pause) begin
          state_d = S_PLAYING;
          presc_d = '0;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
        tl_d    = '0;
        presc_d = '0;
      end
    endcase

    en_d = (state_d == S_PLAYING);
  end

  // Display decode
  logic [LEFT_W-1:0] left_bin;
  logic [BCD_W-1:0]  left_bcd, score_bcd, lvl_bcd;

  assign left_bin = (state_q == S_GAME_OVER) ? LEFT_W'(hi_q) : LEFT_W'(tl_q);

  bin2bcd99 #(.IN_W(LEFT_W))  u_left  (.bin(left_bin), .bcd(left_bcd));
  bin2bcd99 #(.IN_W(SCORE_W)) u_right (.bin(score),    .bcd(score_bcd));
  bin2bcd99 #(.IN_W(LVL_W))   u_level (.bin(lvl_q),    .bcd(lvl_bcd));

  assign display_left  = (state_q == S_IDLE) ? '0 : left_bcd;
  assign display_right = (state_q == S_IDLE) ? lvl_bcd : score_bcd;

  assign state_o          = state_q;
  assign enable_score     = en_q;
  assign enable_mole_ctrl = en_q;
  assign clear_score      = clr_q;
  assign difficulty_level = lvl_q;
  assign time_left        = tl_q;
  assign hi_score         = hi_q;
  assign game_over_pulse  = go_q;
  assign new_hi_pulse     = nh_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed scenarios plus randomized buttons against a reference model.
module tb_game_sequencer;

  localparam int TICK = 4;
  localparam int CD   = 3;
  localparam int GS   = 5;
  localparam int NL   = 3;
`ifdef GAME_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic       clk, rst_n;
  logic       btn_start, btn_pause, btn_clear_score, btn_difficulty;
  logic [7:0] score;
  logic [2:0] state_o;
  logic       enable_score, enable_mole_ctrl, clear_score;
  logic [1:0] difficulty_level;
  logic [6:0] time_left;
  logic [7:0] display_left, display_right, hi_score;
  logic       game_over_pulse, new_hi_pulse;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_state, m_tl, m_phase, m_lvl, m_hi, m_clr, m_go, m_nh;

  game_sequencer #(
    .TICK_CYCLES(TICK), .COUNTDOWN_SEC(CD), .GAME_SEC(GS), .SCORE_W(8), .N_LEVELS(NL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_start(btn_start), .btn_pause(btn_pause),
    .btn_clear_score(btn_clear_score), .btn_difficulty(btn_difficulty),
    .score(score), .state_o(state_o),
    .enable_score(enable_score), .enable_mole_ctrl(enable_mole_ctrl),
    .clear_score(clear_score), .difficulty_level(difficulty_level),
    .time_left(time_left), .display_left(display_left), .display_right(display_right),
    .hi_score(hi_score), .game_over_pulse(game_over_pulse), .new_hi_pulse(new_hi_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    int s;
    s = (v > 99) ? 99 : v;
    return 8'((s / 10) * 16 + (s % 10));
  endfunction

  task automatic model_reset();
    m_state = 0; m_tl = 0; m_phase = 0; m_lvl = 0;
    m_hi = 0; m_clr = 0; m_go = 0; m_nh = 0;
  endtask

  // Game rules applied once per clock; states: 0 idle, 1 countdown, 2 playing, 3 paused, 4 over
  task automatic model_step(input bit st, input bit ps, input bit cl, input bit df, input int sc);
    int  cur;
    bit  counting, sec_done;
    cur      = m_state;
    counting = (cur == 1) || (cur == 2);
    sec_done = counting && (m_phase == TICK - 1);
    m_clr = 0; m_go = 0; m_nh = 0;
    if (counting) m_phase = sec_done ? 0 : m_phase + 1;
    if (cur == 0 || cur == 4) begin
      m_phase = 0;
      if (df) m_lvl = (m_lvl + 1) % NL;
      if (st) begin m_state = 1; m_tl = CD; m_clr = 1; end
      else if (cl) begin m_clr = 1; m_hi = 0; end
    end else if (cur == 1) begin
      if (st) begin m_tl = CD; m_phase = 0; end
      else if (sec_done) begin
        if (m_tl == 1) begin m_state = 2; m_tl = GS; end
        else m_tl = m_tl - 1;
      end
    end else if (cur == 2) begin
      if (st) begin m_state = 1; m_tl = CD; m_phase = 0; m_clr = 1; end
      else if (sec_done) begin
        m_tl = m_tl - 1;
        if (m_tl == 0) begin
          m_state = 4; m_go = 1;
          if (sc > m_hi) begin m_hi = sc; m_nh = 1; end
        end
      end
      else if (ps && PAUSE_EN) m_state = 3;
      else if (cl) m_clr = 1;
    end else begin
      if (st) begin m_state = 1; m_tl = CD; m_phase = 0; m_clr = 1; end
      else if (ps) begin m_state = 2; m_phase = 0; end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step(btn_start, btn_pause, btn_clear_score, btn_difficulty, int'(score));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic press_start();
    btn_start = 1'b1; cycle(); btn_start = 1'b0;
  endtask

  task automatic do_reset();
    btn_start = 0; btn_pause = 0; btn_clear_score = 0; btn_difficulty = 0;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; score = 8'd0;
    btn_start = 0; btn_pause = 0; btn_clear_score = 0; btn_difficulty = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    checks++; if (time_left !== 7'd0) begin errors++; $display("FAIL reset_time: got %0d expected 0", time_left); end
    checks++; if (hi_score !== 8'd0) begin errors++; $display("FAIL reset_hi: got %0d expected 0", hi_score); end
    checks++; if (difficulty_level !== 2'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", difficulty_level); end
    checks++; if ({clear_score, game_over_pulse, new_hi_pulse, enable_score, enable_mole_ctrl} !== 5'b0) begin
      errors++; $display("FAIL reset_pulses: got %b expected 00000",
        {clear_score, game_over_pulse, new_hi_pulse, enable_score, enable_mole_ctrl}); end
    checks++; if ({display_left, display_right} !== 16'h0000) begin
      errors++; $display("FAIL reset_display: got %h expected 0000", {display_left, display_right}); end
    @(negedge clk) rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_rounds();
    score = 8'd42;
    press_start();
    checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL r1_countdown: got %0d expected 1", state_o); end
    checks++; if (display_left !== 8'h03) begin errors++; $display("FAIL r1_left03: got %h expected 03", display_left); end
    checks++; if (clear_score !== 1'b1) begin errors++; $display("FAIL r1_clear: got %b expected 1", clear_score); end
    cycle();
    checks++; if (clear_score !== 1'b0) begin errors++; $display("FAIL r1_clear_once: got %b expected 0", clear_score); end
    cycles(10);
    checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL r1_still_cd: got %0d expected 1", state_o); end
    cycle();
    checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL r1_playing: got %0d expected 2", state_o); end
    checks++; if (display_left !== 8'h05) begin errors++; $display("FAIL r1_left05: got %h expected 05", display_left); end
    checks++; if ({enable_score, enable_mole_ctrl} !== 2'b11) begin
      errors++; $display("FAIL r1_enables: got %b expected 11", {enable_score, enable_mole_ctrl}); end
    cycles(19);
    checks++; if (state_o !== 3'd2 || time_left !== 7'd1) begin
      errors++; $display("FAIL r1_last_sec: got state %0d time %0d expected 2/1", state_o, time_left); end
    cycle();
    checks++; if (state_o !== 3'd4) begin errors++; $display("FAIL r1_over: got %0d expected 4", state_o); end
    checks++; if ({game_over_pulse, new_hi_pulse} !== 2'b11) begin
      errors++; $display("FAIL r1_pulses: got %b expected 11", {game_over_pulse, new_hi_pulse}); end
    checks++; if (hi_score !== 8'd42) begin errors++; $display("FAIL r1_hi: got %0d expected 42", hi_score); end
    checks++; if (time_left !== 7'd0 || enable_score !== 1'b0) begin
      errors++; $display("FAIL r1_over_time: got time %0d en %b expected 0/0", time_left, enable_score); end
    cycle();
    checks++; if ({game_over_pulse, new_hi_pulse} !== 2'b00) begin
      errors++; $display("FAIL r1_pulse_once: got %b expected 00", {game_over_pulse, new_hi_pulse}); end
    // Round two with a lower score keeps the record
    score = 8'd17;
    press_start();
    cycles(32);
    checks++; if (state_o !== 3'd4 || game_over_pulse !== 1'b1) begin
      errors++; $display("FAIL r2_over: got state %0d go %b expected 4/1", state_o, game_over_pulse); end
    checks++; if (new_hi_pulse !== 1'b0) begin errors++; $display("FAIL r2_no_new_hi: got %b expected 0", new_hi_pulse); end
    checks++; if (hi_score !== 8'd42) begin errors++; $display("FAIL r2_hi: got %0d expected 42", hi_score); end
    checks++; if (display_left !== 8'h42 || display_right !== 8'h17) begin
      errors++; $display("FAIL r2_display: got %h%h expected 4217", display_left, display_right); end
  endtask

  task automatic test_difficulty();
    int exp_lvl[4] = '{1, 2, 0, 1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      btn_difficulty = 1'b1; cycle(); btn_difficulty = 1'b0;
      checks++; if (difficulty_level !== 2'(exp_lvl[i]) || display_right !== bcd(exp_lvl[i])) begin
        errors++; $display("FAIL diff_step%0d: got lvl %0d disp %h expected %0d", i, difficulty_level, display_right, exp_lvl[i]); end
    end
    press_start();
    cycles(12);
    checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL diff_playing: got %0d expected 2", state_o); end
    btn_difficulty = 1'b1; cycle(); btn_difficulty = 1'b0;
    checks++; if (difficulty_level !== 2'd1) begin errors++; $display("FAIL diff_locked: got %0d expected 1", difficulty_level); end
  endtask

  task automatic test_start_on_tick();
    do_reset();
    press_start();
    cycles(11);
    checks++; if (state_o !== 3'd1 || time_left !== 7'd1) begin
      errors++; $display("FAIL sot_pre: got state %0d time %0d expected 1/1", state_o, time_left); end
    press_start();
    checks++; if (state_o !== 3'd1 || time_left !== 7'd3) begin
      errors++; $display("FAIL sot_reload: got state %0d time %0d expected 1/3", state_o, time_left); end
    cycles(3);
    checks++; if (time_left !== 7'd3) begin errors++; $display("FAIL sot_presc_zero: got %0d expected 3", time_left); end
    cycle();
    checks++; if (time_left !== 7'd2) begin errors++; $display("FAIL sot_next_sec: got %0d expected 2", time_left); end
  endtask

  task automatic test_pause();
    do_reset();
    press_start();
    cycles(16);
    checks++; if (state_o !== 3'd2 || time_left !== 7'd4) begin
      errors++; $display("FAIL pause_pre: got state %0d time %0d expected 2/4", state_o, time_left); end
    btn_pause = 1'b1; cycle(); btn_pause = 1'b0;
    if (PAUSE_EN) begin
      cycles(40);
      checks++; if (state_o !== 3'd3 || time_left !== 7'd4) begin
        errors++; $display("FAIL pause_frozen: got state %0d time %0d expected 3/4", state_o, time_left); end
      checks++; if ({enable_score, enable_mole_ctrl} !== 2'b00) begin
        errors++; $display("FAIL pause_enables: got %b expected 00", {enable_score, enable_mole_ctrl}); end
      btn_pause = 1'b1; cycle(); btn_pause = 1'b0;
      checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL pause_resume: got %0d expected 2", state_o); end
      cycles(3);
      checks++; if (time_left !== 7'd4) begin errors++; $display("FAIL pause_hold: got %0d expected 4", time_left); end
      cycle();
      checks++; if (time_left !== 7'd3) begin errors++; $display("FAIL pause_dec: got %0d expected 3", time_left); end
    end else begin
      checks++; if (state_o !== 3'd2 || enable_score !== 1'b1) begin
        errors++; $display("FAIL nopause_state: got state %0d en %b expected 2/1", state_o, enable_score); end
      cycles(3);
      checks++; if (time_left !== 7'd3) begin errors++; $display("FAIL nopause_dec: got %0d expected 3", time_left); end
    end
  endtask

  task automatic test_saturation_reset();
    do_reset();
    score = 8'd150;
    press_start();
    cycles(12);
    checks++; if (display_right !== 8'h99 || display_left !== 8'h05) begin
      errors++; $display("FAIL sat_play: got %h%h expected 0599", display_left, display_right); end
    cycles(20);
    checks++; if (hi_score !== 8'd150 || display_left !== 8'h99) begin
      errors++; $display("FAIL sat_over: got hi %0d left %h expected 150/99", hi_score, display_left); end
    press_start();
    cycles(14);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (state_o !== 3'd0 || hi_score !== 8'd0 || time_left !== 7'd0 || enable_score !== 1'b0) begin
      errors++; $display("FAIL async_reset: got state %0d hi %0d time %0d en %b expected 0/0/0/0",
        state_o, hi_score, time_left, enable_score); end
    model_reset();
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [7:0] exp_l, exp_r;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      btn_start       = ($urandom_range(0, 59) == 0);
      btn_pause       = ($urandom_range(0, 39) == 0);
      btn_clear_score = ($urandom_range(0, 29) == 0);
      btn_difficulty  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) score = 8'($urandom_range(0, 255));
      cycle();
      if (m_state == 0) begin exp_l = 8'h00; exp_r = bcd(m_lvl); end
      else if (m_state == 4) begin exp_l = bcd(m_hi); exp_r = bcd(int'(score)); end
      else begin exp_l = bcd(m_tl); exp_r = bcd(int'(score)); end
      checks++; if (state_o !== 3'(m_state)) begin errors++; $display("FAIL rnd_state c%0d: got %0d expected %0d", i, state_o, m_state); end
      checks++; if (time_left !== 7'(m_tl)) begin errors++; $display("FAIL rnd_time c%0d: got %0d expected %0d", i, time_left, m_tl); end
      checks++; if (difficulty_level !== 2'(m_lvl)) begin errors++; $display("FAIL rnd_level c%0d: got %0d expected %0d", i, difficulty_level, m_lvl); end
      checks++; if (hi_score !== 8'(m_hi)) begin errors++; $display("FAIL rnd_hi c%0d: got %0d expected %0d", i, hi_score, m_hi); end
      checks++; if ({clear_score, game_over_pulse, new_hi_pulse} !== {1'(m_clr), 1'(m_go), 1'(m_nh)}) begin
        errors++; $display("FAIL rnd_pulses c%0d: got %b expected %b", i,
          {clear_score, game_over_pulse, new_hi_pulse}, {1'(m_clr), 1'(m_go), 1'(m_nh)}); end
      checks++; if ({enable_score, enable_mole_ctrl} !== {2{m_state == 2}}) begin
        errors++; $display("FAIL rnd_enables c%0d: got %b expected %b", i, {enable_score, enable_mole_ctrl}, {2{m_state == 2}}); end
      checks++; if (display_left !== exp_l || display_right !== exp_r) begin
        errors++; $display("FAIL rnd_display c%0d: got %h%h expected %h%h", i, display_left, display_right, exp_l, exp_r); end
    end
    btn_start = 0; btn_pause = 0; btn_clear_score = 0; btn_difficulty = 0;
  endtask

  initial begin
    test_reset();
    test_rounds();
    test_difficulty();
    test_start_on_tick();
    test_pause();
    test_saturation_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
